line_write_buffer: RTL and testbench

LINE_WRITE_BUFFER -- requirements
Module: line_write_buffer

---
 rtl/line_write_buffer.sv | 154 +++++++++++++++
 tb/tb_line_write_buffer.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_write_buffer.sv
// line_write_buffer: DEPTH-entry FIFO of evicted 256-bit lines between the arbiter and the adaptor.
// Rev 1.0 -- read hits, write coalescing, idle-time draining.
`default_nettype none

module line_write_buffer #(
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         up_read,
   input  logic         up_write,
   input  logic [31:0]  up_address,
   input  logic [255:0] up_wdata,
   output logic [255:0] up_rdata,
   output logic         up_resp,
   output logic         dn_read,
   output logic         dn_write,
   output logic [31:0]  dn_address,
   output logic [255:0] dn_wdata,
   input  logic [255:0] dn_rdata,
   input  logic         dn_resp
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_FWD_READ = 2'd1,
      S_DRAIN    = 2'd2,
      S_RESP     = 2'd3
   } state_t;

   state_t             state_q;
   logic [PTR_W-1:0]   head_q;
   logic [PTR_W-1:0]   tail_q;
   logic [CNT_W-1:0]   count_q;
   logic [DEPTH-1:0]   valid_q;
   logic [26:0]        tag_q  [DEPTH];
   logic [255:0]       data_q [DEPTH];
   logic [255:0]       up_rdata_q;
   logic               up_resp_q;
   logic               dn_read_q;
   logic               dn_write_q;
   logic [31:0]        dn_address_q;
   logic [255:0]       dn_wdata_q;

   logic               w_hit;
   logic [PTR_W-1:0]   w_hit_idx;
   logic               w_unused;

   // Coalescing keeps at most one valid entry per tag, so the match is unique.
   always_comb begin
      w_hit     = 1'b0;
      w_hit_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i] && (tag_q[i] == up_address[31:5])) begin
            w_hit     = 1'b1;
            w_hit_idx = PTR_W'(i);
         end
      end
   end

   assign w_unused = ^up_address[4:0];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         head_q       <= '0;
         tail_q       <= '0;
         count_q      <= '0;
         valid_q      <= '0;
         up_rdata_q   <= '0;
         up_resp_q    <= 1'b0;
         dn_read_q    <= 1'b0;
         dn_write_q   <= 1'b0;
         dn_address_q <= '0;
         dn_wdata_q   <= '0;
      end else begin
         up_resp_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (up_read) begin
                  if (w_hit) begin
                     up_rdata_q <= data_q[w_hit_idx];
                     up_resp_q  <= 1'b1;
                     state_q    <= S_RESP;
                  end else begin
                     dn_read_q    <= 1'b1;
                     dn_address_q <= {up_address[31:5], 5'b0};
                     state_q      <= S_FWD_READ;
                  end
               end else if (up_write) begin
                  if (w_hit) begin
                     data_q[w_hit_idx] <= up_wdata;
                     up_resp_q         <= 1'b1;
                     state_q           <= S_RESP;
                  end else if (count_q != C_FULL) begin
                     tag_q[tail_q]   <= up_address[31:5];
                     data_q[tail_q]  <= up_wdata;
                     valid_q[tail_q] <= 1'b1;
                     tail_q          <= tail_q + 1'b1;
                     count_q         <= count_q + 1'b1;
                     up_resp_q       <= 1'b1;
                     state_q         <= S_RESP;
                  end else begin
                     // Full: free the head first, the write is retried back in IDLE.
                     dn_write_q   <= 1'b1;
                     dn_address_q <= {tag_q[head_q], 5'b0};
                     dn_wdata_q   <= data_q[head_q];
                     state_q      <= S_DRAIN;
                  end
               end else if (count_q != '0) begin
                  dn_write_q   <= 1'b1;
                  dn_address_q <= {tag_q[head_q], 5'b0};
                  dn_wdata_q   <= data_q[head_q];
                  state_q      <= S_DRAIN;
               end
            end
            S_FWD_READ: begin
               if (dn_resp) begin
                  dn_read_q  <= 1'b0;
                  up_rdata_q <= dn_rdata;
                  up_resp_q  <= 1'b1;
                  state_q    <= S_RESP;
               end
            end
            S_DRAIN: begin
               if (dn_resp) begin
                  dn_write_q      <= 1'b0;
                  valid_q[head_q] <= 1'b0;
                  head_q          <= head_q + 1'b1;
                  count_q         <= count_q - 1'b1;
                  state_q         <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign up_rdata   = up_rdata_q;
   assign up_resp    = up_resp_q;
   assign dn_read    = dn_read_q;
   assign dn_write   = dn_write_q;
   assign dn_address = dn_address_q;
   assign dn_wdata   = dn_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_line_write_buffer.sv
// tb_line_write_buffer: directed + short random sequence against a golden memory and drain-order scoreboard.
// Rev 1.0
`default_nettype none

module tb_line_write_buffer;

   typedef struct packed {
      logic [26:0]  tag;
      logic [255:0] data;
   } ent_t;

   typedef struct packed {
      logic         rd;
      logic [255:0] data;
   } exp_t;

   logic         clk;
   logic         reset_n;
   logic         up_read;
   logic         up_write;
   logic [31:0]  up_address;
   logic [255:0] up_wdata;
   logic [255:0] up_rdata;
   logic         up_resp;
   logic         dn_read;
   logic         dn_write;
   logic [31:0]  dn_address;
   logic [255:0] dn_wdata;
   logic [255:0] dn_rdata;
   logic         dn_resp;

   line_write_buffer #(.DEPTH(4)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .up_read    (up_read),
      .up_write   (up_write),
      .up_address (up_address),
      .up_wdata   (up_wdata),
      .up_rdata   (up_rdata),
      .up_resp    (up_resp),
      .dn_read    (dn_read),
      .dn_write   (dn_write),
      .dn_address (dn_address),
      .dn_wdata   (dn_wdata),
      .dn_rdata   (dn_rdata),
      .dn_resp    (dn_resp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int n_dn_wr = 0;
   int n_dn_rd = 0;
   int dn_lat = 1;
   int resp_cyc = 0;
   int up_cyc = 0;
   bit resp_en = 1'b1;
   bit dn_busy = 1'b0;
   int dn_cnt = 0;
   logic [31:0]  dn_cap_a;
   logic [255:0] dn_cap_d;
   logic         dn_cap_w;
   logic [31:0]  pend_addr = '0;
   logic [31:0]  last_drain_a = '0;

   logic [255:0] mem [logic [31:0]];
   logic [255:0] gm  [logic [31:0]];
   ent_t         model_q [$];
   exp_t         up_q [$];

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] memval(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : {8{a}};
   endfunction

   function automatic logic [255:0] rnd256();
      return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   // One clock; sample #1 after the edge and play the adaptor.
   task automatic step();
      ent_t e;
      @(posedge clk);
      #1;
      cyc++;
      chk("dn_excl", 256'(dn_read & dn_write), 256'd0);
      if (dn_resp) begin
         dn_resp = 1'b0;
      end else if (resp_en && reset_n && (dn_read || dn_write)) begin
         if (!dn_busy) begin
            dn_busy  = 1'b1;
            dn_cnt   = 0;
            dn_cap_a = dn_address;
            dn_cap_d = dn_wdata;
            dn_cap_w = dn_write;
            if (dn_write) begin
               n_dn_wr++;
               last_drain_a = dn_address;
               chk("drain_expected", 256'(model_q.size() != 0), 256'd1);
               if (model_q.size() != 0) begin
                  e = model_q.pop_front();
                  chk("drain_addr", 256'(dn_address), 256'({e.tag, 5'b0}));
                  chk("drain_data", dn_wdata, e.data);
               end
            end else begin
               n_dn_rd++;
               chk("fwd_addr", 256'(dn_address), 256'({pend_addr[31:5], 5'b0}));
            end
         end else begin
            chk("dn_stable", 256'(dn_address === dn_cap_a && dn_wdata === dn_cap_d
                                 && dn_write === dn_cap_w), 256'd1);
         end
         dn_cnt++;
         if (dn_cnt >= dn_lat) begin
            dn_resp  = 1'b1;
            dn_busy  = 1'b0;
            resp_cyc = cyc;
            if (dn_cap_w) mem[dn_cap_a] = dn_cap_d;
            else          dn_rdata = memval(dn_cap_a);
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // lat counts the request's own cycle, so a hit answered in RESP reports 2.
   task automatic up_txn(input bit rd, input logic [31:0] a, input logic [255:0] wd,
                         input string tag, output int lat);
      logic [31:0] la;
      exp_t        x;
      int          idx;
      bit          got;
      la        = {a[31:5], 5'b0};
      pend_addr = a;
      x.rd      = rd;
      x.data    = '0;
      if (rd) begin
         x.data = gm.exists(la) ? gm[la] : memval(la);
      end else begin
         gm[la] = wd;
         idx = -1;
         foreach (model_q[i]) if (model_q[i].tag == a[31:5]) idx = i;
         if (idx >= 0) model_q[idx].data = wd;
         else          model_q.push_back('{tag: a[31:5], data: wd});
      end
      up_q.push_back(x);
      up_read    = rd;
      up_write   = !rd;
      up_address = a;
      up_wdata   = wd;
      lat = 0;
      got = 1'b0;
      while (!got && lat < 80) begin
         step();
         lat++;
         if (up_resp) got = 1'b1;
      end
      up_cyc   = cyc;
      up_read  = 1'b0;
      up_write = 1'b0;
      chk({tag, "_resp"}, 256'(got), 256'd1);
      x = up_q.pop_front();
      if (got && x.rd) chk({tag, "_rdata"}, up_rdata, x.data);
      step();
      chk({tag, "_pulse"}, 256'(up_resp), 256'd0);
      lat = lat + 1;
   endtask

   initial begin
      int lat;
      int w0;
      int r0;
      logic [31:0]  ra;
      logic [255:0] dA, dB, dC, dD, dE;
      reset_n    = 1'b0;
      up_read    = 1'b0;
      up_write   = 1'b0;
      up_address = '0;
      up_wdata   = '0;
      dn_rdata   = '0;
      dn_resp    = 1'b0;
      dA = rnd256(); dB = rnd256(); dC = rnd256(); dD = rnd256(); dE = rnd256();

      idle(3);
      chk("rst_up_resp",    256'(up_resp),    256'd0);
      chk("rst_up_rdata",   up_rdata,         256'd0);
      chk("rst_dn_read",    256'(dn_read),    256'd0);
      chk("rst_dn_write",   256'(dn_write),   256'd0);
      chk("rst_dn_address", 256'(dn_address), 256'd0);
      chk("rst_dn_wdata",   dn_wdata,         256'd0);
      reset_n = 1'b1;
      idle(4);
      chk("empty_no_drain", 256'(n_dn_wr), 256'd0);

      // Write then read-hit, including a read with non-zero offset bits.
      up_txn(1'b0, 32'h1000, dA, "wr_1000", lat);
      chk("wr_lat", 256'(lat), 256'd2);
      r0 = n_dn_rd;
      up_txn(1'b1, 32'h1000, '0, "rd_hit", lat);
      chk("rd_hit_lat", 256'(lat), 256'd2);
      up_txn(1'b1, 32'h101F, '0, "rd_hit_off", lat);
      chk("rd_hit_off_lat", 256'(lat), 256'd2);
      chk("rd_hit_no_dnread", 256'(n_dn_rd), 256'(r0));
      idle(8);
      chk("drain_1000_cnt", 256'(n_dn_wr), 256'd1);
      chk("drain_1000_empty", 256'(model_q.size()), 256'd0);

      // Miss on empty buffer forwarded with a 5-cycle adaptor.
      mem[32'h2000] = dB;
      dn_lat = 5;
      r0 = n_dn_rd;
      up_txn(1'b1, 32'h2000, '0, "rd_fwd", lat);
      chk("rd_fwd_dnread", 256'(n_dn_rd - r0), 256'd1);
      chk("rd_fwd_resp_next", 256'(up_cyc - resp_cyc), 256'd1);

      // Fill to DEPTH, fifth write waits for one drain of the oldest line.
      dn_lat = 3;
      w0 = n_dn_wr;
      for (int i = 0; i < 4; i++) begin
         up_txn(1'b0, 32'h100 + 32'(i * 32), rnd256(), "wr_fill", lat);
         chk("wr_fill_lat", 256'(lat), 256'd2);
      end
      up_txn(1'b0, 32'h180, rnd256(), "wr_full", lat);
      chk("wr_full_waits", 256'(lat > 2), 256'd1);
      chk("wr_full_one_drain", 256'(n_dn_wr - w0), 256'd1);
      chk("wr_full_drain_addr", 256'(last_drain_a), 256'h100);
      idle(40);
      chk("full_drain_total", 256'(n_dn_wr - w0), 256'd5);
      chk("full_drain_empty", 256'(model_q.size()), 256'd0);

      // Coalescing: two writes to one line produce one drain carrying the newer data.
      dn_lat = 1;
      w0 = n_dn_wr;
      up_txn(1'b0, 32'h300, dC, "wr_300_c", lat);
      up_txn(1'b0, 32'h300, dD, "wr_300_d", lat);
      chk("coalesce_lat", 256'(lat), 256'd2);
      idle(10);
      chk("coalesce_one_drain", 256'(n_dn_wr - w0), 256'd1);
      chk("coalesce_mem", mem[32'h300], dD);

      // Two fill/drain rounds of three, so head/tail wrap.
      for (int rnd = 0; rnd < 2; rnd++) begin
         w0 = n_dn_wr;
         for (int i = 0; i < 3; i++)
            up_txn(1'b0, 32'h500 + 32'((rnd * 3 + i) * 32), rnd256(), "wr_round", lat);
         r0 = n_dn_rd;
         up_txn(1'b1, 32'h500 + 32'((rnd * 3 + 1) * 32), '0, "rd_round_hit", lat);
         chk("rd_round_lat", 256'(lat), 256'd2);
         chk("rd_round_no_dnread", 256'(n_dn_rd - r0), 256'd0);
         idle(12);
         chk("round_drains", 256'(n_dn_wr - w0), 256'd3);
         chk("round_empty", 256'(model_q.size()), 256'd0);
      end
      up_txn(1'b1, 32'h160, '0, "rd_drained", lat);

      // Reset with a drain outstanding; the late dn_resp must be ignored.
      resp_en = 1'b0;
      up_txn(1'b0, 32'h400, dE, "wr_400", lat);
      for (int i = 0; i < 10 && !dn_write; i++) step();
      chk("rst_drain_started", 256'(dn_write), 256'd1);
      chk("rst_drain_addr", 256'(dn_address), 256'h400);
      idle(2);
      reset_n = 1'b0;
      step();
      chk("midrst_dn_write",   256'(dn_write),   256'd0);
      chk("midrst_dn_read",    256'(dn_read),    256'd0);
      chk("midrst_up_resp",    256'(up_resp),    256'd0);
      chk("midrst_dn_address", 256'(dn_address), 256'd0);
      chk("midrst_dn_wdata",   dn_wdata,         256'd0);
      reset_n = 1'b1;
      model_q.delete();
      gm = mem;
      dn_busy = 1'b0;
      w0 = n_dn_wr;
      dn_resp = 1'b1;
      step();
      chk("late_resp_up_resp", 256'(up_resp), 256'd0);
      chk("late_resp_dn_write", 256'(dn_write), 256'd0);
      idle(3);
      chk("post_rst_no_drain", 256'(dn_write), 256'd0);
      resp_en = 1'b1;
      dn_lat  = 2;
      r0 = n_dn_rd;
      up_txn(1'b1, 32'h400, '0, "rd_after_rst", lat);
      chk("rd_after_rst_dnread", 256'(n_dn_rd - r0), 256'd1);
      chk("post_rst_drains", 256'(n_dn_wr - w0), 256'd0);

      // Short random mix over a handful of lines.
      for (int i = 0; i < 24; i++) begin
         ra = 32'h600 + 32'($urandom_range(0, 5) * 32) + 32'($urandom_range(0, 31));
         dn_lat = $urandom_range(1, 4);
         if ($urandom_range(0, 2) == 0) up_txn(1'b1, ra, '0, "rnd_rd", lat);
         else                            up_txn(1'b0, ra, rnd256(), "rnd_wr", lat);
         idle($urandom_range(0, 3));
      end
      idle(60);
      chk("rnd_final_empty", 256'(model_q.size()), 256'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
